// File: rtl/data_mem_if.sv
// data_mem_if: request/response bus between the L1 data cache and data_mem
// Signals:
//   writeEn    1 = store, 0 = load            (cache -> memory)
//   addr       byte address                   (cache -> memory)
//   func3      RISC-V funct3 width/sign code  (cache -> memory)
//   storeVal   right-aligned store data       (cache -> memory)
//   loadVal    registered load result         (memory -> cache)
//   data_ready request complete, level        (memory -> cache)
interface data_mem_if;
   logic        writeEn;
   logic [31:0] addr;
   logic [2:0]  func3;
   logic [31:0] storeVal;
   logic [31:0] loadVal;
   logic        data_ready;
   modport master (output writeEn, addr, func3, storeVal, input loadVal, data_ready);
   modport slave (input writeEn, addr, func3, storeVal, output loadVal, data_ready);
endinterface

// File: rtl/data_mem.sv
// data_mem: word-organised, byte-addressable RISC-V data RAM with LATENCY-edge access
module data_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter     INIT_FILE   = "datamem.hex"
) (
  input logic       clk,
  input logic       reset,
  data_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  logic [31:0]   mem [DEPTH_WORDS];
  logic          valid, l_we, ready;
  logic [31:0]   l_addr, l_store, load_q;
  logic [2:0]    l_f3;
  logic [CW-1:0] cnt;
  logic          new_req, fire;
  logic [AW-1:0] idx;
  logic [31:0]   word, rdata, wdata;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [3:0]    be;
  assign new_req = !valid || {bus.addr, bus.writeEn, bus.func3, bus.storeVal} != {l_addr, l_we, l_f3, l_store};
  assign fire = !new_req && !ready && cnt == CW'(LATENCY);
  assign idx = l_addr[AW+1:2];
  assign word = mem[idx];
  assign byte_sel = word[{l_addr[1:0], 3'b000} +: 8];
  assign half_sel = l_addr[1] ? word[31:16] : word[15:0];
  assign rdata = l_f3 == 3'd0 ? {{24{byte_sel[7]}}, byte_sel} :
                 l_f3 == 3'd1 ? {{16{half_sel[15]}}, half_sel} :
                 l_f3 == 3'd4 ? {24'd0, byte_sel} :
                 l_f3 == 3'd5 ? {16'd0, half_sel} : word;
  assign be = l_f3 == 3'd0 ? 4'b0001 << l_addr[1:0] :
              l_f3 == 3'd1 ? (l_addr[1] ? 4'b1100 : 4'b0011) :
              l_f3 == 3'd2 ? 4'b1111 : 4'b0000;
  assign wdata = l_f3 == 3'd0 ? {4{l_store[7:0]}} : l_f3 == 3'd1 ? {2{l_store[15:0]}} : l_store;
  assign bus.loadVal = load_q;
  assign bus.data_ready = ready;
  always_ff @(posedge clk)
    if (fire && l_we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid   <= 1'b0;
      l_addr  <= '0;
      l_we    <= 1'b0;
      l_f3    <= '0;
      l_store <= '0;
      cnt     <= '0;
      ready   <= 1'b0;
      load_q  <= '0;
    end else if (new_req) begin
      valid   <= 1'b1;
      l_addr  <= bus.addr;
      l_we    <= bus.writeEn;
      l_f3    <= bus.func3;
      l_store <= bus.storeVal;
      cnt     <= CW'(1);
      ready   <= 1'b0;
    end else if (fire) begin
      ready <= 1'b1;
      if (!l_we) load_q <= rdata;
    end else if (!ready) cnt <= cnt + CW'(1);
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed-vector bench for data_mem with a byte-array reference model
module tb_data_mem;
   localparam int LATENCY = 2;
   localparam int BYTES   = 4 * 1024;
   logic clk, reset;
   int   n_chk = 0, n_fail = 0;
   data_mem_if bus ();
   data_mem #(.DEPTH_WORDS(1024), .LATENCY(LATENCY)) dut (.clk(clk), .reset(reset), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // reference model: memory as a flat byte array, requests tracked by the edge they first appeared
   bit [7:0]    mb [BYTES];
   logic        m_ready = 1'b0, have = 1'b0;
   logic [31:0] m_load = '0;
   logic [67:0] cur, tup;
   int          edge_no = 0, t0 = 0;
   task automatic execute(input logic we, input logic [31:0] a_in, input logic [2:0] f3, input logic [31:0] sv);
      int a, w, h;
      logic [7:0]  b;
      logic [15:0] hw;
      logic [31:0] wd;
      a  = int'(a_in % BYTES);
      w  = a - a % 4;
      h  = a - a % 2;
      b  = mb[a];
      hw = {mb[h+1], mb[h]};
      wd = {mb[w+3], mb[w+2], mb[w+1], mb[w]};
      if (!we)
         case (f3)
            3'd0: m_load = $signed(b);
            3'd1: m_load = $signed(hw);
            3'd4: m_load = {24'd0, b};
            3'd5: m_load = {16'd0, hw};
            default: m_load = wd;
         endcase
      else
         case (f3)
            3'd0: mb[a] = sv[7:0];
            3'd1: begin mb[h] = sv[7:0]; mb[h+1] = sv[15:8]; end
            3'd2: for (int i = 0; i < 4; i++) mb[w+i] = sv[8*i +: 8];
            default: ;
         endcase
   endtask
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         have    = 1'b0;
         m_ready = 1'b0;
         m_load  = '0;
      end else begin
         edge_no++;
         tup = {bus.addr, bus.writeEn, bus.func3, bus.storeVal};
         if (!have || tup != cur) begin
            have    = 1'b1;
            cur     = tup;
            t0      = edge_no;
            m_ready = 1'b0;
         end else if (edge_no - t0 == LATENCY) begin
            m_ready = 1'b1;
            execute(bus.writeEn, bus.addr, bus.func3, bus.storeVal);
         end
      end
   end
   always @(negedge clk) begin
      chk("cyc_ready", {31'd0, bus.data_ready}, {31'd0, m_ready});
      chk("cyc_load", bus.loadVal, m_load);
   end
   task automatic set_req(input logic we, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] sv);
      bus.writeEn  = we;
      bus.addr     = a;
      bus.func3    = f3;
      bus.storeVal = sv;
   endtask
   // call at a negedge right after the tuple changed; expects completion LATENCY edges later
   task automatic wait_ready(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.data_ready && n < 20);
      chk(name, n, LATENCY + 1);
   endtask
   task automatic op(input string name, input logic we, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] sv);
      @(negedge clk);
      set_req(we, a, f3, sv);
      wait_ready(name);
   endtask
   task automatic ld(input string name, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] exp);
      op(name, 1'b0, a, f3, 32'h0);
      chk(name, bus.loadVal, exp);
   endtask
   initial begin
      reset = 1'b0;
      set_req(1'b1, 32'h40, 3'd2, 32'h11111111);
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_load", bus.loadVal, 32'h0);
      chk("rst_ready", {31'd0, bus.data_ready}, 32'h0);
      reset = 1'b0;
      wait_ready("first_after_rst");
      op("sw_10", 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
      ld("lw_10", 32'h10, 3'd2, 32'hDEADBEEF);
      op("sb_13", 1'b1, 32'h13, 3'd0, 32'h000000AA);
      chk("store_keeps_load", bus.loadVal, 32'hDEADBEEF);
      op("sh_10", 1'b1, 32'h10, 3'd1, 32'h00001234);
      ld("lw_merge", 32'h10, 3'd2, 32'hAAAD1234);
      op("sh_beef", 1'b1, 32'h10, 3'd1, 32'h0000BEEF);
      ld("lb_13", 32'h13, 3'd0, 32'hFFFFFFAA);
      ld("lbu_13", 32'h13, 3'd4, 32'h000000AA);
      ld("lh_10", 32'h10, 3'd1, 32'hFFFFBEEF);
      ld("lhu_12", 32'h12, 3'd5, 32'h0000AAAD);
      ld("lh_11", 32'h11, 3'd1, 32'hFFFFBEEF);
      ld("lb_10", 32'h10, 3'd0, 32'hFFFFFFEF);
      ld("lbu_11", 32'h11, 3'd4, 32'h000000BE);
      ld("lw_f3_3", 32'h13, 3'd3, 32'hAAADBEEF);
      ld("lw_f3_7", 32'h10, 3'd7, 32'hAAADBEEF);
      repeat (3) @(negedge clk);
      chk("ready_held", {31'd0, bus.data_ready}, 32'h1);
      op("sw_20", 1'b1, 32'h20, 3'd2, 32'h77777777);
      op("sw_24", 1'b1, 32'h24, 3'd2, 32'h01010101);
      @(negedge clk);
      set_req(1'b1, 32'h20, 3'd2, 32'hCAFEF00D);
      @(negedge clk);
      chk("abort_pre", {31'd0, bus.data_ready}, 32'h0);
      bus.addr = 32'h24;
      wait_ready("abort_restart");
      ld("lw_20_kept", 32'h20, 3'd2, 32'h77777777);
      ld("lw_24_new", 32'h24, 3'd2, 32'hCAFEF00D);
      op("sw_wrap", 1'b1, 32'h1010, 3'd2, 32'h0BADF00D);
      ld("lw_wrap", 32'h10, 3'd2, 32'h0BADF00D);
      op("sw_f3_3", 1'b1, 32'h10, 3'd3, 32'h12345678);
      op("sw_f3_7", 1'b1, 32'h10, 3'd7, 32'h87654321);
      ld("lw_after_bad", 32'h10, 3'd2, 32'h0BADF00D);
      op("sw_30", 1'b1, 32'h30, 3'd2, 32'h55555555);
      ld("lw_30", 32'h30, 3'd2, 32'h55555555);
      @(negedge clk);
      set_req(1'b1, 32'h30, 3'd2, 32'h66666666);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_load", bus.loadVal, 32'h0);
      chk("mid_rst_ready", {31'd0, bus.data_ready}, 32'h0);
      @(negedge clk);
      set_req(1'b0, 32'h30, 3'd2, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      wait_ready("after_mid_rst");
      chk("lw_30_kept", bus.loadVal, 32'h55555555);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
